// File: rtl/hourglass_stream_sorter.sv
// ============================================================================
//  Module   : hourglass_stream_sorter
//  Purpose  : Streaming insertion sorter. Keys arrive on an AXI-Stream style
//             input, are inserted into a sorted register array one per cycle
//             (FILL), then leave head-first one per cycle (DRAIN) together
//             with their arrival index inside the batch. Ordering is stable.
//  Ports    : clk, rst                      - clock, sync active-high reset
//             axis_in_key/valid/ready/last  - input stream
//             axis_out_key/index            - sorted key and arrival index
//             axis_out_valid/ready/last     - output stream handshake
//             overflow                      - only with the macro below
//  Config   : `define HOURGLASS_STREAM_SORTER_OVERFLOW_EN to close batches
//             only on axis_in_last and discard (and flag) keys that arrive
//             once the array is full.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hourglass_stream_sorter #(
  parameter int NUMBER_OF_ELEMENTS = 21,
  parameter int KEY_WIDTH          = 8,
  parameter int OUTPUT_INDEX_WIDTH = 5,
  parameter bit DESCENDING         = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [KEY_WIDTH-1:0]          axis_in_key,
  input  logic                          axis_in_valid,
  output logic                          axis_in_ready,
  input  logic                          axis_in_last,
  output logic [KEY_WIDTH-1:0]          axis_out_key,
  output logic [OUTPUT_INDEX_WIDTH-1:0] axis_out_index,
  output logic                          axis_out_valid,
  input  logic                          axis_out_ready,
  output logic                          axis_out_last
`ifdef HOURGLASS_STREAM_SORTER_OVERFLOW_EN
  ,output logic                         overflow
`endif
);

  localparam int                c_CNT_W = $clog2(NUMBER_OF_ELEMENTS + 1);
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(NUMBER_OF_ELEMENTS);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Single occupancy counter: number of stored keys while filling, number of
  // keys still to leave while draining. It reaches zero on the final output.
  logic [c_CNT_W-1:0] r_count;

  logic [KEY_WIDTH-1:0]          r_key [NUMBER_OF_ELEMENTS];
  logic [OUTPUT_INDEX_WIDTH-1:0] r_idx [NUMBER_OF_ELEMENTS];

  logic [KEY_WIDTH-1:0]          w_ins_key   [NUMBER_OF_ELEMENTS];
  logic [OUTPUT_INDEX_WIDTH-1:0] w_ins_idx   [NUMBER_OF_ELEMENTS];
  logic [KEY_WIDTH-1:0]          w_shift_key [NUMBER_OF_ELEMENTS];
  logic [OUTPUT_INDEX_WIDTH-1:0] w_shift_idx [NUMBER_OF_ELEMENTS];
  logic [NUMBER_OF_ELEMENTS-1:0] w_before;

  logic                          w_in_hs;
  logic                          w_out_hs;
  logic                          w_store;
  logic                          w_close;
  logic                          w_out_final;
  logic [OUTPUT_INDEX_WIDTH-1:0] w_new_idx;

  assign w_in_hs     = axis_in_valid && (r_state == S_FILL);
  assign w_out_hs    = axis_out_ready && (r_state == S_DRAIN);
  assign w_out_final = w_out_hs && (r_count == c_ONE);
  // Keys beyond capacity can only be seen with the overflow option; they are
  // accepted but never written into the array.
  assign w_store     = w_in_hs && (r_count != c_FULL);
  assign w_new_idx   = OUTPUT_INDEX_WIDTH'(r_count);

`ifdef HOURGLASS_STREAM_SORTER_OVERFLOW_EN
  assign w_close = w_in_hs && axis_in_last;
`else
  assign w_close = w_in_hs && (axis_in_last || (r_count == (c_FULL - c_ONE)));
`endif

  // --------------------------------------------------------------------------
  // Sorted array. w_before[i] marks occupied slots whose key must stay ahead
  // of the incoming key; equal keys stay ahead, which keeps the sort stable.
  // Because the array is sorted, w_before is a run of ones followed by zeros:
  // the first zero slot takes the new key and every later slot shifts by one.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUMBER_OF_ELEMENTS; i++) begin : g_slot
    assign w_before[i] = (c_CNT_W'(i) < r_count) &&
                         (DESCENDING ? (r_key[i] >= axis_in_key)
                                     : (r_key[i] <= axis_in_key));

    if (i == 0) begin : g_head
      assign w_ins_key[i] = w_before[i] ? r_key[i] : axis_in_key;
      assign w_ins_idx[i] = w_before[i] ? r_idx[i] : w_new_idx;
    end else begin : g_body
      assign w_ins_key[i] = w_before[i]   ? r_key[i]    :
                            w_before[i-1] ? axis_in_key : r_key[i-1];
      assign w_ins_idx[i] = w_before[i]   ? r_idx[i]    :
                            w_before[i-1] ? w_new_idx   : r_idx[i-1];
    end

    if (i < NUMBER_OF_ELEMENTS - 1) begin : g_shift
      assign w_shift_key[i] = r_key[i+1];
      assign w_shift_idx[i] = r_idx[i+1];
    end else begin : g_tail
      assign w_shift_key[i] = r_key[i];
      assign w_shift_idx[i] = r_idx[i];
    end

    // Data path only; occupancy is tracked by r_count so no reset is needed.
    always_ff @(posedge clk) begin
      if (w_store) begin
        r_key[i] <= w_ins_key[i];
        r_idx[i] <= w_ins_idx[i];
      end else if (w_out_hs) begin
        r_key[i] <= w_shift_key[i];
        r_idx[i] <= w_shift_idx[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Occupancy counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_store) begin
      r_count <= r_count + c_ONE;
    end else if (w_out_hs) begin
      r_count <= r_count - c_ONE;
    end
  end

`ifdef HOURGLASS_STREAM_SORTER_OVERFLOW_EN
  logic r_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_in_hs && (r_count == c_FULL)) begin
      r_overflow <= 1'b1;
    end else if (w_out_final) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    axis_in_ready  = 1'b0;
    axis_out_valid = 1'b0;
    axis_out_last  = 1'b0;
    axis_out_key   = '0;
    axis_out_index = '0;
    case (r_state)
      S_FILL: begin
        axis_in_ready = 1'b1;
        if (w_close) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        axis_out_valid = 1'b1;
        axis_out_key   = r_key[0];
        axis_out_index = r_idx[0];
        axis_out_last  = (r_count == c_ONE);
        if (w_out_final) begin
          w_state_next = S_FILL;
        end
      end
      default: begin
        w_state_next = S_FILL;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_hourglass_stream_sorter.sv
// ============================================================================
//  Module   : tb_hourglass_stream_sorter
//  Purpose  : Self-checking bench for hourglass_stream_sorter. An ascending
//             and a descending instance share the same stimulus; expected
//             output order comes from a rank-counting reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hourglass_stream_sorter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_key;
  logic       in_valid;
  logic       in_last;
  logic       out_ready;

  logic       in_ready_a, in_ready_d;
  logic [7:0] a_key, d_key;
  logic [4:0] a_idx, d_idx;
  logic       a_valid, d_valid, a_last, d_last;
`ifdef HOURGLASS_STREAM_SORTER_OVERFLOW_EN
  logic       ovf_a, ovf_d;
`endif

  int tests = 0;
  int fails = 0;

  logic [7:0] bk     [0:31];
  logic [7:0] ea_key [0:31];
  logic [4:0] ea_idx [0:31];
  logic [7:0] ed_key [0:31];
  logic [4:0] ed_idx [0:31];

  always #5 clk = ~clk;

  hourglass_stream_sorter #(.DESCENDING(1'b0)) dut_a (
    .clk(clk), .rst(rst),
    .axis_in_key(in_key), .axis_in_valid(in_valid), .axis_in_ready(in_ready_a),
    .axis_in_last(in_last),
    .axis_out_key(a_key), .axis_out_index(a_idx), .axis_out_valid(a_valid),
    .axis_out_ready(out_ready), .axis_out_last(a_last)
`ifdef HOURGLASS_STREAM_SORTER_OVERFLOW_EN
    ,.overflow(ovf_a)
`endif
  );

  hourglass_stream_sorter #(.DESCENDING(1'b1)) dut_d (
    .clk(clk), .rst(rst),
    .axis_in_key(in_key), .axis_in_valid(in_valid), .axis_in_ready(in_ready_d),
    .axis_in_last(in_last),
    .axis_out_key(d_key), .axis_out_index(d_idx), .axis_out_valid(d_valid),
    .axis_out_ready(out_ready), .axis_out_last(d_last)
`ifdef HOURGLASS_STREAM_SORTER_OVERFLOW_EN
    ,.overflow(ovf_d)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output position of key j = number of keys that must precede it: strictly
  // better keys plus equal keys that arrived earlier.
  task automatic compute_model(input int n);
    for (int j = 0; j < n; j++) begin
      int ra = 0;
      int rd = 0;
      for (int k = 0; k < n; k++) begin
        if (bk[k] < bk[j] || (bk[k] == bk[j] && k < j)) ra++;
        if (bk[k] > bk[j] || (bk[k] == bk[j] && k < j)) rd++;
      end
      ea_key[ra] = bk[j]; ea_idx[ra] = 5'(j);
      ed_key[rd] = bk[j]; ed_idx[rd] = 5'(j);
    end
  endtask

  task automatic send_keys(input int n, input bit use_last);
    for (int j = 0; j < n; j++) begin
      in_valid = 1'b1;
      in_key   = bk[j];
      in_last  = use_last && (j == n - 1);
      check("in_ready_fill", in_ready_a, 1'b1);
      check("out_valid_fill", a_valid, 1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready
  task automatic recv(input int n, input int mode);
    int pos = 0;
    int cyc = 0;
    while (pos < n && cyc < 400) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      check("out_valid_a", a_valid, 1'b1);
      check("out_valid_d", d_valid, 1'b1);
      check("in_ready_drain", in_ready_a, 1'b0);
      check("key_a", a_key, ea_key[pos]);
      check("idx_a", a_idx, ea_idx[pos]);
      check("last_a", a_last, (pos == n - 1));
      check("key_d", d_key, ed_key[pos]);
      check("idx_d", d_idx, ed_idx[pos]);
      check("last_d", d_last, (pos == n - 1));
      if (out_ready) pos++;
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    check("handshake_count", pos, n);
    check("valid_after_a", a_valid, 1'b0);
    check("valid_after_d", d_valid, 1'b0);
    check("in_ready_after_a", in_ready_a, 1'b1);
    check("in_ready_after_d", in_ready_d, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_key = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", in_ready_a, 1'b1);
    check("rst_out_valid", a_valid, 1'b0);
    check("rst_out_last", a_last, 1'b0);
    check("rst_out_key", a_key, 8'h00);
    check("rst_out_idx", a_idx, 5'h00);
    check("rst_out_valid_d", d_valid, 1'b0);

    // Directed 3,1,3,0,1 with hand-derived expectations
    bk[0] = 8'd3; bk[1] = 8'd1; bk[2] = 8'd3; bk[3] = 8'd0; bk[4] = 8'd1;
    ea_key[0] = 8'd0; ea_key[1] = 8'd1; ea_key[2] = 8'd1; ea_key[3] = 8'd3; ea_key[4] = 8'd3;
    ea_idx[0] = 5'd3; ea_idx[1] = 5'd1; ea_idx[2] = 5'd4; ea_idx[3] = 5'd0; ea_idx[4] = 5'd2;
    ed_key[0] = 8'd3; ed_key[1] = 8'd3; ed_key[2] = 8'd1; ed_key[3] = 8'd1; ed_key[4] = 8'd0;
    ed_idx[0] = 5'd0; ed_idx[1] = 5'd2; ed_idx[2] = 5'd1; ed_idx[3] = 5'd4; ed_idx[4] = 5'd3;
    send_keys(5, 1'b1);
    recv(5, 0);

    // Back-pressure on a full-size random batch
    for (int j = 0; j < 21; j++) bk[j] = 8'($urandom_range(0, 15));
    send_keys(21, 1'b1);
    compute_model(21);
    recv(21, 1);

    // Random batches: mixed lengths, duplicate-heavy and full-range keys
    for (int b = 0; b < 6; b++) begin
      int n = $urandom_range(1, 21);
      for (int j = 0; j < n; j++)
        bk[j] = (b % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      send_keys(n, 1'b1);
      compute_model(n);
      recv(n, b % 3);
    end

`ifdef HOURGLASS_STREAM_SORTER_OVERFLOW_EN
    // 23 keys, last on the 23rd: the two extra keys are accepted and dropped
    for (int j = 0; j < 23; j++) bk[j] = 8'($urandom);
    for (int j = 0; j < 23; j++) begin
      in_valid = 1'b1;
      in_key   = bk[j];
      in_last  = (j == 22);
      check("ovf_in_ready", in_ready_a, 1'b1);
      @(posedge clk); #1;
      if (j == 20) check("ovf_low_at_21", ovf_a, 1'b0);
      if (j == 21) check("ovf_high_at_22", ovf_a, 1'b1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("ovf_high_drain_a", ovf_a, 1'b1);
    check("ovf_high_drain_d", ovf_d, 1'b1);
    compute_model(21);
    recv(21, 2);
    check("ovf_cleared", ovf_a, 1'b0);
`else
    // 21 keys without last close the batch; a 22nd key waits for the next one
    for (int j = 0; j < 21; j++) bk[j] = 8'($urandom);
    send_keys(21, 1'b0);
    compute_model(21);
    in_valid = 1'b1; in_key = 8'hAA; in_last = 1'b1;
    recv(21, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    bk[0] = 8'hAA;
    compute_model(1);
    recv(1, 0);
`endif

    // Reset in the middle of a drain discards the rest of the batch
    for (int j = 0; j < 6; j++) bk[j] = 8'($urandom);
    send_keys(6, 1'b1);
    compute_model(6);
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check("pre_rst_key", a_key, ea_key[k]);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", a_valid, 1'b0);
    check("midrst_in_ready", in_ready_a, 1'b1);
    check("midrst_last", a_last, 1'b0);
    bk[0] = 8'd5;
    send_keys(1, 1'b1);
    check("single_key", a_key, 8'd5);
    check("single_idx", a_idx, 5'd0);
    check("single_last", a_last, 1'b1);
    compute_model(1);
    recv(1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
